// File: rtl/fpu_mul.sv
// fpu_mul: IEEE-754 single-precision multiplier with an iterative shift-add
// significand datapath retiring BITS_PER_CYCLE multiplier bits per cycle.
// Flush-to-zero on subnormal inputs and outputs.
// Optional feature: define FPU_MUL_RNE_EN for round-to-nearest-even;
// the default build truncates (round toward zero) and still reports inexact.
module fpu_mul #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam int unsigned N_CYC = 24 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t state_q, state_d;

  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [47:0]        acc_q;
  logic [47:0]        mcand_q;
  logic [23:0]        mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  logic        accept;
  logic [7:0]  ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        special;
  logic        sign_in;
  logic [31:0] spec_result;
  logic [3:0]  spec_flags;

  logic [47:0]       acc_sum;
  logic [23:0]       mant;
  logic              g_bit, s_bit, rnd_inc, inexact;
  logic [24:0]       mant_rnd;
  logic [22:0]       mant_fin;
  logic signed [9:0] e_pre, e_fin;
  logic [31:0]       norm_result;
  logic [3:0]        norm_flags;

  assign accept  = in_valid && in_ready;
  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign sign_in = a[31] ^ b[31];

  // Operand classification; subnormals count as zero
  always_comb begin
    a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
  end

  // Result of the special-case path (NaN, inf*0, inf, zero)
  always_comb begin
    spec_result = {sign_in, 31'd0};
    spec_flags  = 4'b0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_result = 32'h7FC0_0000;
      spec_flags  = 4'b1000;
    end else if (a_inf || b_inf) begin
      spec_result = {sign_in, 8'hFF, 23'd0};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : MUL;
      MUL:  if (cnt_q == CNT_W'(N_CYC - 1)) state_d = NORM;
      NORM: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake outputs track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // One iteration of shift-add: add shifted multiplicand for each set multiplier bit
  always_comb begin
    acc_sum = acc_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (mplier_q[i]) acc_sum = acc_sum + (mcand_q << i);
    end
  end

  // Significand multiplier and exponent/sign capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      acc_q    <= 48'd0;
      mcand_q  <= 48'd0;
      mplier_q <= 24'd0;
      cnt_q    <= '0;
    end else if (state_q == IDLE && accept) begin
      sign_q   <= sign_in;
      exp_q    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      acc_q    <= 48'd0;
      mcand_q  <= {24'd0, 1'b1, a[22:0]};
      mplier_q <= {1'b1, b[22:0]};
      cnt_q    <= '0;
    end else if (state_q == MUL) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << BITS_PER_CYCLE;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Normalize, round and range-check the finished product
  always_comb begin
    if (acc_q[47]) begin
      mant  = acc_q[47:24];
      g_bit = acc_q[23];
      s_bit = |acc_q[22:0];
      e_pre = exp_q + 10'sd1;
    end else begin
      mant  = acc_q[46:23];
      g_bit = acc_q[22];
      s_bit = |acc_q[21:0];
      e_pre = exp_q;
    end
`ifdef FPU_MUL_RNE_EN
    rnd_inc = g_bit & (s_bit | mant[0]);
`else
    rnd_inc = 1'b0;
`endif
    mant_rnd = {1'b0, mant} + 25'(rnd_inc);
    if (mant_rnd[24]) begin
      mant_fin = mant_rnd[23:1];
      e_fin    = e_pre + 10'sd1;
    end else begin
      mant_fin = mant_rnd[22:0];
      e_fin    = e_pre;
    end
    inexact = g_bit | s_bit;
    if (e_fin >= 10'sd255) begin
      norm_result = {sign_q, 8'hFF, 23'd0};
      norm_flags  = 4'b0101;
    end else if (e_fin <= 10'sd0) begin
      norm_result = {sign_q, 31'd0};
      norm_flags  = 4'b0011;
    end else begin
      norm_result = {sign_q, e_fin[7:0], mant_fin};
      norm_flags  = {3'b000, inexact};
    end
  end

  // Result and flags load only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= 32'd0;
      flags  <= 4'd0;
    end else if (state_q == IDLE && accept && special) begin
      result <= spec_result;
      flags  <= spec_flags;
    end else if (state_q == NORM) begin
      result <= norm_result;
      flags  <= norm_flags;
    end
  end

endmodule

// File: doc/fpu_mul.md
FPU_MUL -- requirements
Module: fpu_mul

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1, giving the mantissa multiplier bits retired per cycle; legal values are 1, 2, 4, 8.
REQ-002 SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  32  IEEE-754 single-precision operand A.
- b  in  32  IEEE-754 single-precision operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  IEEE-754 product a*b.
- flags  out  4  {invalid, overflow, underflow, inexact}.

Function
REQ-003 SHALL implement the FSM IDLE -> MUL -> NORM -> DONE -> IDLE, plus the special-case path IDLE -> DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; operands are accepted on the rising edge where in_valid && in_ready, and a and b are captured.
REQ-005 On accept with a special operand, the FSM SHALL go directly to DONE, and out_valid SHALL rise 1 cycle after the accept edge.
REQ-006 On accept with normal operands, the FSM SHALL do MUL for N = 24/BITS_PER_CYCLE cycles (shift-add of the 24-bit significands into a 48-bit product), then NORM for 1 cycle; out_valid SHALL rise N+2 cycles after the accept edge.
REQ-007 Sign SHALL be sign_a XOR sign_b for every result, including zero and infinity.
REQ-008 Exponent SHALL be computed as 10-bit signed ea+eb-127; if product bit 47 is set, the product is shifted right 1 and the exponent incremented.
REQ-009 Rounding SHALL use guard bit G (first dropped bit) and sticky S (OR of the remaining dropped bits); a mantissa carry-out after rounding SHALL increment the exponent.
REQ-010 Final exponent >= 255 SHALL give signed infinity with overflow=1 and inexact=1.
REQ-011 Final exponent <= 0 SHALL give signed zero (flush-to-zero, no subnormal output) with underflow=1 and inexact=1.
REQ-012 Subnormal inputs (exp=0, mant!=0) SHALL be treated as signed zero.
REQ-013 Any NaN input SHALL give 0x7FC00000 with invalid=1.
REQ-014 Infinity times zero (either operand order) SHALL give 0x7FC00000 with invalid=1.
REQ-015 Infinity times a nonzero finite value SHALL give signed infinity with flags=0.
REQ-016 Zero times a finite value SHALL give signed zero with flags=0.
REQ-017 inexact SHALL be 1 whenever G|S=1 on the normal path.
REQ-018 In DONE, out_valid SHALL stay 1 and result/flags SHALL stay stable until out_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-019 No new operand SHALL be accepted on the same edge that a result is consumed; in_ready rises the cycle after.
REQ-020 result and flags SHALL be registered and change only on entry to DONE.

Reset
REQ-021 rst_n low SHALL asynchronously force: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, and clear the multiplier accumulator and counter.
REQ-022 Reset asserted mid-MUL, NORM or DONE SHALL abort the operation and output nothing for it after release.

Configuration
REQ-023 With macro FPU_MUL_RNE_EN defined, rounding SHALL be round-to-nearest-even: increment if G && (S || lsb).
REQ-024 Without FPU_MUL_RNE_EN, rounding SHALL be truncation (round toward zero), and flags.inexact SHALL still be reported.

Verification
REQ-025 The bench SHALL cover these scenarios:
- 0x40000000 * 0x40400000 -> 0x40C00000, flags=0, out_valid at accept+26 (BITS_PER_CYCLE=1).
- 0x3FC00001 * 0x3FC00001 -> 0x40100002 with RNE_EN, 0x40100001 without; inexact=1 in both.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1, out_valid at accept+1.
- 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1, inexact=1.
- 0x00800000 * 0x00800000 -> 0x00000000, underflow=1; 0x80000000 * 0x3F800000 -> 0x80000000, flags=0.
- Hold out_ready=0 for 5 cycles -> result stable, in_ready=0. Pull rst_n low mid-MUL -> out_valid=0, in_ready=1 immediately.
